// File: rtl/cell_selector.sv
// Cursor controller for the 3x3 board: debounces move/select buttons, steps the cursor cell and reports confirmed free cells.
// Optional SKIP_OCUPADO_EN: cursor auto-skips taken cells through the BUSCAR state.

module cell_selector_debounce #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic ev
);
    localparam int W = $clog2(CYCLES + 1);

    logic         sync1;
    logic         sync2;
    logic         stable;
    logic         stable_d;
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 != stable) begin
                if (cnt == W'(CYCLES)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // only presses matter; releases are filtered but produce no event
    assign ev = stable & ~stable_d;
endmodule

module cell_selector #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       boton_rst,
    input  logic       boton_mover,
    input  logic       boton_sel,
    input  logic [8:0] ocupado,
    output logic [3:0] contador,
    output logic       sel_valid,
    output logic [3:0] sel_cell,
    output logic       lleno
);
    // state  | meaning
    // IDLE   | waiting for move/select events
    // BUSCAR | stepping past taken cells (SKIP_OCUPADO_EN only)
    // LLENO  | board full, cursor frozen until a cell frees up
`ifdef SKIP_OCUPADO_EN
    typedef enum logic [1:0] {IDLE, BUSCAR, LLENO} state_t;
`else
    typedef enum logic [1:0] {IDLE, LLENO} state_t;
`endif

    state_t     state;
    logic       ev_mover;
    logic       ev_sel;
    logic [3:0] cur;
    logic [3:0] nxt;

    cell_selector_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_mover (
        .clk (clk),
        .rst (boton_rst),
        .raw (boton_mover),
        .ev  (ev_mover)
    );

    cell_selector_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
        .clk (clk),
        .rst (boton_rst),
        .raw (boton_sel),
        .ev  (ev_sel)
    );

    // out-of-range cursor values collapse to 0
    assign cur = (contador > 4'd8) ? 4'd0 : contador;
    assign nxt = (contador >= 4'd8) ? 4'd0 : contador + 4'd1;

    always_ff @(posedge clk) begin
        if (boton_rst) begin
            state     <= IDLE;
            contador  <= 4'd0;
            sel_valid <= 1'b0;
            sel_cell  <= 4'd0;
            lleno     <= 1'b0;
        end else begin
            lleno     <= &ocupado;
            sel_valid <= 1'b0;
            contador  <= cur;
            case (state)
                IDLE: begin
                    if (lleno) begin
                        state <= LLENO;
                    end else if (ev_sel) begin
                        if (!ocupado[cur]) begin
                            sel_valid <= 1'b1;
                            sel_cell  <= cur;
                        end
                    end else if (ev_mover) begin
                        contador <= nxt;
                    end
`ifdef SKIP_OCUPADO_EN
                    else if (ocupado[cur]) begin
                        contador <= nxt;
                        if (ocupado[nxt]) state <= BUSCAR;
                    end
`endif
                end
`ifdef SKIP_OCUPADO_EN
                BUSCAR: begin
                    if (lleno) begin
                        state <= LLENO;
                    end else begin
                        contador <= nxt;
                        if (!ocupado[nxt]) state <= IDLE;
                    end
                end
`endif
                LLENO: begin
                    if (!lleno) begin
                        contador <= 4'd0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_selector.sv
// Directed bench for cell_selector with a short debounce; skip tests are compiled only with SKIP_OCUPADO_EN.
`timescale 1ns/1ps

module tb_cell_selector;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       boton_rst = 1'b1;
    logic       boton_mover = 1'b0;
    logic       boton_sel = 1'b0;
    logic [8:0] ocupado = 9'd0;
    logic [3:0] contador;
    logic       sel_valid;
    logic [3:0] sel_cell;
    logic       lleno;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    typedef struct {
        logic [8:0] ocup;
        int         btn;      // 1 move, 2 select, 3 both together
        int         exp_cnt;
        int         exp_pulses;
        int         exp_cell;
        int         exp_lleno;
    } vec_t;

    vec_t tv[16];

    cell_selector #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .boton_rst   (boton_rst),
        .boton_mover (boton_mover),
        .boton_sel   (boton_sel),
        .ocupado     (ocupado),
        .contador    (contador),
        .sel_valid   (sel_valid),
        .sel_cell    (sel_cell),
        .lleno       (lleno)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sel_valid === 1'b1) pulses = pulses + 1;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int btn, input int hold);
        if (btn == 1 || btn == 3) boton_mover = 1'b1;
        if (btn == 2 || btn == 3) boton_sel = 1'b1;
        cycles(hold);
        boton_mover = 1'b0;
        boton_sel   = 1'b0;
        cycles(12);
    endtask

    initial begin
        int p0;
        int exp_hold;

        for (int i = 0; i < 8; i++) tv[i] = '{9'd0, 1, (i + 2) % 9, 0, 0, 0};
        for (int i = 0; i < 4; i++) tv[8 + i] = '{9'd0, 1, i + 1, 0, 0, 0};
        tv[12] = '{9'd0, 2, 4, 1, 4, 0};
        tv[13] = '{9'd0, 1, 5, 0, 4, 0};
        tv[14] = '{9'd0, 3, 5, 1, 5, 0};
        tv[15] = '{9'd0, 1, 6, 0, 5, 0};

        cycles(2);
        check("rst_contador", contador, 0);
        check("rst_sel_valid", sel_valid, 0);
        check("rst_sel_cell", sel_cell, 0);
        check("rst_lleno", lleno, 0);
        boton_rst = 1'b0;

        // press first sampled at edge 0; cursor must move exactly at edge D+3
        boton_mover = 1'b1;
        cycles(D + 3);
        check("deb_before_edge", contador, 0);
        cycles(1);
        check("deb_at_edge", contador, 1);
        cycles(10 - (D + 4));
        boton_mover = 1'b0;
        cycles(12);
        check("deb_single_step", contador, 1);

        press(1, D - 1);
        check("glitch_ignored", contador, 1);

        for (int i = 0; i < 16; i++) begin
            ocupado = tv[i].ocup;
            p0 = pulses;
            press(tv[i].btn, 10);
            check($sformatf("vec%0d_contador", i), contador, tv[i].exp_cnt);
            check($sformatf("vec%0d_pulses", i), pulses - p0, tv[i].exp_pulses);
            check($sformatf("vec%0d_sel_cell", i), sel_cell, tv[i].exp_cell);
            check($sformatf("vec%0d_lleno", i), lleno, tv[i].exp_lleno);
        end

`ifndef SKIP_OCUPADO_EN
        ocupado = 9'b011000000;
        p0 = pulses;
        press(2, 10);
        check("occ_sel_pulses", pulses - p0, 0);
        check("occ_sel_cell", sel_cell, 5);
        check("occ_sel_contador", contador, 6);
        press(1, 10);
        check("occ_move_onto_taken", contador, 7);
        ocupado = 9'd0;
        exp_hold = 7;
`else
        ocupado = 9'b110000001;
        p0 = pulses;
        boton_mover = 1'b1;
        cycles(2);
        boton_sel = 1'b1;
        cycles(5);
        check("skip_edge6", contador, 6);
        cycles(1);
        check("skip_edge7", contador, 7);
        cycles(1);
        check("skip_edge8", contador, 8);
        cycles(1);
        check("skip_edge9", contador, 0);
        cycles(1);
        check("skip_edge10", contador, 1);
        boton_mover = 1'b0;
        boton_sel   = 1'b0;
        cycles(12);
        check("skip_rests_idle", contador, 1);
        check("skip_sel_dropped", pulses - p0, 0);
        check("skip_sel_cell", sel_cell, 5);
        ocupado = 9'd0;
        exp_hold = 2;
`endif

        ocupado = 9'h1FF;
        check("full_lleno_latency0", lleno, 0);
        cycles(1);
        check("full_lleno_latency1", lleno, 1);
        p0 = pulses;
        press(1, 10);
        press(2, 10);
        check("full_contador_hold", contador, exp_hold);
        check("full_no_pulse", pulses - p0, 0);
        ocupado = 9'd0;
        cycles(3);
        check("recover_contador", contador, 0);
        check("recover_lleno", lleno, 0);
        press(1, 10);
        check("recover_idle_move", contador, 1);

        // reset while LLENO and with a move half debounced
        ocupado = 9'h1FF;
        boton_mover = 1'b1;
        p0 = pulses;
        cycles(5);
        check("pre_rst_lleno", lleno, 1);
        boton_rst = 1'b1;
        cycles(1);
        boton_rst   = 1'b0;
        boton_mover = 1'b0;
        ocupado     = 9'd0;
        check("midrst_contador", contador, 0);
        check("midrst_sel_valid", sel_valid, 0);
        check("midrst_sel_cell", sel_cell, 0);
        check("midrst_lleno", lleno, 0);
        cycles(15);
        check("midrst_no_event", contador, 0);
        check("midrst_no_pulse", pulses - p0, 0);
        press(1, 10);
        check("postrst_move", contador, 1);

`ifdef SKIP_OCUPADO_EN
        ocupado = 9'b001111110;
        cycles(1);
        check("busrst_step1", contador, 2);
        cycles(1);
        check("busrst_step2", contador, 3);
        boton_rst = 1'b1;
        cycles(1);
        boton_rst = 1'b0;
        check("busrst_contador", contador, 0);
        cycles(3);
        check("busrst_stays_idle", contador, 0);
        ocupado = 9'd0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
